cmem_write_loader: RTL and testbench

//  Upstream feeder of the per-row CGRA context memories. Accepts kernel-load writes from the

---
 rtl/cmem_write_loader.sv | 140 ++++++++++++++
 tb/tb_cmem_write_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_write_loader.sv
// Kernel-load write buffer and shared-port arbiter for the per-row CGRA context memories.
// Bus writes are decoded into row/line, queued in a small FIFO, and drained into the
// context-memory port whenever no row controller is fetching (fetch has absolute priority).
module cmem_write_loader #(
    parameter int unsigned N_ROW        = 4,
    parameter int unsigned IMEM_N_LINES = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  wr_valid_i,
    output logic                                  wr_ready_o,
    input  logic [31:0]                           wr_addr_i,
    input  logic [DATA_WIDTH-1:0]                 wr_data_i,
    input  logic                                  wr_bcast_i,
    input  logic [N_ROW-1:0]                      fetch_req_i,
    input  logic [$clog2(IMEM_N_LINES)-1:0]       fetch_addr_i,
    output logic [N_ROW-1:0]                      cm_row_req_o,
    output logic                                  cm_we_o,
    output logic [$clog2(IMEM_N_LINES)-1:0]       cm_addr_o,
    output logic [DATA_WIDTH-1:0]                 cm_wdata_o,
    output logic                                  busy_o,
    output logic                                  err_o,
    input  logic                                  err_clr_i,
    output logic [15:0]                           wr_count_o,
    input  logic                                  count_clr_i
);

    localparam int unsigned ROW_W   = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int unsigned LINE_W  = $clog2(IMEM_N_LINES);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned ROW_LSB = 2 + LINE_W;
    localparam int unsigned HI_LSB  = ROW_LSB + ROW_W;

    typedef struct packed {
        logic                  bcast;
        logic [ROW_W-1:0]      row;
        logic [LINE_W-1:0]     line;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    entry_t             head;
    entry_t             new_entry;
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic               full;
    logic               empty;
    logic [LINE_W-1:0]  dec_line;
    logic [ROW_W-1:0]   dec_row;
    logic               dec_err;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fetch_active;

    // Address decode of the incoming beat into row/line plus error detection
    always_comb begin
        dec_line  = wr_addr_i[2 +: LINE_W];
        dec_row   = wr_addr_i[ROW_LSB +: ROW_W];
        dec_err   = (|wr_addr_i[1:0]) | (|wr_addr_i[31:HI_LSB])
                  | (!wr_bcast_i && (32'(dec_row) >= N_ROW));
        new_entry = '{bcast: wr_bcast_i, row: dec_row, line: dec_line, data: wr_data_i};
    end

    // FIFO status and handshake; a full FIFO refuses beats even if it pops this cycle
    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        wr_ready_o   = !full && !rst_i;
        accept       = wr_valid_i && wr_ready_o;
        push         = accept && !dec_err;
        fetch_active = |fetch_req_i;
        pop          = !empty && !fetch_active && !rst_i;
        head         = mem[rd_ptr[PTR_W-1:0]];
        busy_o       = !empty;
    end

    // Shared SRAM port mux: fetch first, then FIFO head, else idle; masked in reset
    always_comb begin
        cm_row_req_o = '0;
        cm_we_o      = 1'b0;
        cm_addr_o    = '0;
        cm_wdata_o   = '0;
        if (!rst_i) begin
            if (fetch_active) begin
                cm_row_req_o = fetch_req_i;
                cm_addr_o    = fetch_addr_i;
            end else if (!empty) begin
                cm_row_req_o = head.bcast ? {N_ROW{1'b1}} : (N_ROW'(1) << head.row);
                cm_we_o      = 1'b1;
                cm_addr_o    = head.line;
                cm_wdata_o   = head.data;
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= new_entry;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        end
    end

    // Sticky decode error; a new error outranks a clear in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (accept && dec_err) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

    // Saturating count of writes issued; clear outranks increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_count_o <= '0;
        end else if (count_clr_i) begin
            wr_count_o <= '0;
        end else if (pop && !(&wr_count_o)) begin
            wr_count_o <= wr_count_o + 16'(1);
        end
    end

endmodule

// File: tb/tb_cmem_write_loader.sv
// Self-checking bench for cmem_write_loader: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the loader's behaviour.
module tb_cmem_write_loader;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic        wr_bcast_i;
    logic [3:0]  fetch_req_i;
    logic [4:0]  fetch_addr_i;
    logic [3:0]  cm_row_req_o;
    logic        cm_we_o;
    logic [4:0]  cm_addr_o;
    logic [31:0] cm_wdata_o;
    logic        busy_o;
    logic        err_o;
    logic        err_clr_i;
    logic [15:0] wr_count_o;
    logic        count_clr_i;

    cmem_write_loader dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_bcast_i(wr_bcast_i),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
        .cm_row_req_o(cm_row_req_o), .cm_we_o(cm_we_o), .cm_addr_o(cm_addr_o),
        .cm_wdata_o(cm_wdata_o), .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i),
        .wr_count_o(wr_count_o), .count_clr_i(count_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          bcast;
        int          row;
        int          line;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          m_count;
    bit          m_err;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's view of the current cycle
    task automatic check_all(input string tag);
        logic [3:0]  e_req;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_wdata;
        e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        if (!rst_i) begin
            if (fetch_req_i != 0) begin
                e_req  = fetch_req_i;
                e_addr = fetch_addr_i;
            end else if (q.size() > 0) begin
                e_req   = q[0].bcast ? 4'hF : 4'(1 << q[0].row);
                e_we    = 1;
                e_addr  = 5'(q[0].line);
                e_wdata = q[0].data;
            end
        end
        chk({tag, ".ready"}, 64'(wr_ready_o), 64'((!rst_i) && (q.size() < DEPTH)));
        chk({tag, ".busy"},  64'(busy_o),     64'(q.size() != 0));
        chk({tag, ".err"},   64'(err_o),      64'(m_err));
        chk({tag, ".count"}, 64'(wr_count_o), 64'(m_count));
        chk({tag, ".req"},   64'(cm_row_req_o), 64'(e_req));
        chk({tag, ".we"},    64'(cm_we_o),    64'(e_we));
        chk({tag, ".addr"},  64'(cm_addr_o),  64'(e_addr));
        chk({tag, ".wdata"}, 64'(cm_wdata_o), 64'(e_wdata));
    endtask

    function automatic void model_clear();
        q.delete();
        m_count = 0;
        m_err   = 0;
    endfunction

    // Advance one clock, updating the model from the inputs present before the edge
    task automatic tick();
        bit   do_pop, do_acc, derr;
        ent_t e;
        if (rst_i) begin
            @(posedge clk_i); #1;
            model_clear();
            return;
        end
        do_pop = (fetch_req_i == 0) && (q.size() > 0);
        do_acc = wr_valid_i && (q.size() < DEPTH);
        derr   = (wr_addr_i % 4 != 0) || (wr_addr_i >= 32'd512);
        e.bcast = wr_bcast_i;
        e.line  = int'((wr_addr_i / 4) % 32);
        e.row   = int'((wr_addr_i / 128) % 4);
        e.data  = wr_data_i;
        @(posedge clk_i); #1;
        if (count_clr_i)                       m_count = 0;
        else if (do_pop && m_count != 16'hFFFF) m_count = m_count + 1;
        if (do_acc && derr)  m_err = 1;
        else if (err_clr_i)  m_err = 0;
        if (do_pop) void'(q.pop_front());
        if (do_acc && !derr) q.push_back(e);
    endtask

    task automatic idle_inputs();
        wr_valid_i = 0; wr_addr_i = 0; wr_data_i = 0; wr_bcast_i = 0;
        fetch_req_i = 0; fetch_addr_i = 0; err_clr_i = 0; count_clr_i = 0;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1;
        model_clear();
        #1;
        // Reset state
        check_all("rst");
        chk("rst.ready0", 64'(wr_ready_o), 64'(0));
        tick(); tick();
        rst_i = 0; #1;
        check_all("rel");
        chk("rel.ready1", 64'(wr_ready_o), 64'(1));

        // Single write to row 1 line 2
        wr_valid_i = 1; wr_addr_i = 32'h88; wr_data_i = 32'hDEADBEEF;
        tick();
        idle_inputs(); #1;
        check_all("w1");
        chk("w1.req", 64'(cm_row_req_o), 64'(4'b0010));
        chk("w1.wdata", 64'(cm_wdata_o), 64'(32'hDEADBEEF));
        chk("w1.addr", 64'(cm_addr_o), 64'(2));
        tick();
        check_all("w1b");
        chk("w1b.count", 64'(wr_count_o), 64'(1));
        chk("w1b.we", 64'(cm_we_o), 64'(0));

        // Fetch holds the port while five writes are offered
        fetch_req_i = 4'hF; fetch_addr_i = 5;
        for (int i = 0; i < 10; i++) begin
            wr_valid_i = (i < 5);
            wr_addr_i  = 32'(i * 4);
            wr_data_i  = 32'hA000 + 32'(i);
            #1;
            check_all("fetch");
            chk("fetch.addr5", 64'(cm_addr_o), 64'(5));
            tick();
            if (i == 3) chk("fetch.full", 64'(wr_ready_o), 64'(0));
        end
        idle_inputs(); #1;
        for (int i = 0; i < 4; i++) begin
            check_all("drain");
            chk("drain.order", 64'(cm_wdata_o), 64'(32'hA000 + 32'(i)));
            chk("drain.we", 64'(cm_we_o), 64'(1));
            tick();
        end
        check_all("drained");
        chk("drained.count", 64'(wr_count_o), 64'(5));

        // Broadcast write
        wr_valid_i = 1; wr_bcast_i = 1; wr_addr_i = 32'h0C; wr_data_i = 32'h1234;
        tick();
        idle_inputs(); #1;
        check_all("bc");
        chk("bc.req", 64'(cm_row_req_o), 64'(4'hF));
        chk("bc.addr", 64'(cm_addr_o), 64'(3));
        tick();

        // Decode errors are accepted but dropped
        wr_valid_i = 1; wr_addr_i = 32'h202; wr_data_i = 32'h1;
        #1; chk("e1.ready", 64'(wr_ready_o), 64'(1));
        tick();
        wr_addr_i = 32'h400;
        #1; check_all("e1");
        tick();
        idle_inputs(); #1;
        check_all("e2");
        chk("e2.err", 64'(err_o), 64'(1));
        chk("e2.we", 64'(cm_we_o), 64'(0));
        chk("e2.count", 64'(wr_count_o), 64'(6));
        err_clr_i = 1; tick(); err_clr_i = 0; #1;
        check_all("eclr");
        chk("eclr.err", 64'(err_o), 64'(0));

        // Error set beats clear in the same cycle
        wr_valid_i = 1; wr_addr_i = 32'h1; err_clr_i = 1;
        tick(); idle_inputs(); #1;
        chk("eset.win", 64'(err_o), 64'(1));
        err_clr_i = 1; tick(); err_clr_i = 0;

        // Reset in the middle of a pending drain
        fetch_req_i = 4'b0101; fetch_addr_i = 9;
        for (int i = 0; i < 3; i++) begin
            wr_valid_i = 1; wr_addr_i = 32'(i * 128); wr_data_i = 32'hB0 + 32'(i);
            tick();
        end
        wr_valid_i = 0; #1;
        check_all("pre_rst");
        rst_i = 1; #1;
        model_clear();
        check_all("mid_rst");
        chk("mid_rst.req", 64'(cm_row_req_o), 64'(0));
        chk("mid_rst.busy", 64'(busy_o), 64'(0));
        chk("mid_rst.count", 64'(wr_count_o), 64'(0));
        tick();
        rst_i = 0; idle_inputs(); #1;
        for (int i = 0; i < 3; i++) begin
            check_all("post_rst");
            chk("post_rst.we", 64'(cm_we_o), 64'(0));
            tick();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            wr_valid_i = 1'($urandom_range(0, 1));
            wr_bcast_i = ($urandom_range(0, 5) == 0);
            wr_data_i  = $urandom;
            r = int'($urandom_range(0, 15));
            wr_addr_i  = 32'($urandom_range(0, 127)) << 2;
            if (r == 0)      wr_addr_i = wr_addr_i | 32'($urandom_range(1, 3));
            else if (r == 1) wr_addr_i = wr_addr_i | (32'h200 << $urandom_range(0, 22));
            fetch_req_i  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            fetch_addr_i = 5'($urandom_range(0, 31));
            err_clr_i    = ($urandom_range(0, 9) == 0);
            count_clr_i  = ($urandom_range(0, 39) == 0);
            #1;
            check_all("rnd");
            tick();
        end
        idle_inputs(); #1;
        check_all("rnd_end");

        // Counter saturation under continuous writes, then clear
        count_clr_i = 1; tick(); count_clr_i = 0;
        wr_valid_i = 1; wr_addr_i = 0; wr_data_i = 32'h5A;
        for (int i = 0; i < 65540; i++) tick();
        idle_inputs(); #1;
        check_all("sat");
        chk("sat.count", 64'(wr_count_o), 64'(16'hFFFF));
        tick(); tick();
        chk("sat.hold", 64'(wr_count_o), 64'(16'hFFFF));
        count_clr_i = 1; tick(); count_clr_i = 0; #1;
        check_all("cclr");
        chk("cclr.count", 64'(wr_count_o), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
